// File: rtl/rvs_station_if.sv
// Interfaces for the reservation station:
//   dec2rvs_itf : decode/dispatch -> station (modports dec / rvs)
//   rvs2exu_itf : station -> execution unit  (modports rvs / exu)
//   cdb_itf     : common data bus broadcast  (modports mst / slv)

interface dec2rvs_itf #(
    parameter int TAG_W = 4,
    parameter int OPC_W = 4
);
    logic             req;
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [OPC_W-1:0] opc;
    logic             src1_vld;
    logic             src2_vld;
    logic [TAG_W-1:0] src1_tag;
    logic [TAG_W-1:0] src2_tag;
    logic [31:0]      src1_wdata;
    logic [31:0]      src2_wdata;
    logic [11:0]      offset;

    modport dec (
        output req, opc, src1_vld, src2_vld, src1_tag, src2_tag,
               src1_wdata, src2_wdata, offset,
        input  rdy, tag
    );
    modport rvs (
        input  req, opc, src1_vld, src2_vld, src1_tag, src2_tag,
               src1_wdata, src2_wdata, offset,
        output rdy, tag
    );
endinterface

interface rvs2exu_itf #(
    parameter int TAG_W = 4,
    parameter int OPC_W = 4
);
    logic             req;
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [OPC_W-1:0] opc;
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [11:0]      offset;

    modport rvs (
        output req, tag, opc, src1, src2, offset,
        input  rdy
    );
    modport exu (
        input  req, tag, opc, src1, src2, offset,
        output rdy
    );
endinterface

interface cdb_itf #(
    parameter int TAG_W = 4
);
    logic             wr;
    logic [TAG_W-1:0] tag;
    logic [31:0]      wdata;

    modport mst (output wr, tag, wdata);
    modport slv (input  wr, tag, wdata);
endinterface

// File: rtl/rvs_station.sv
// Reservation station: holds dispatched ops until both operands are known
// (from dispatch or snooped off the CDB), then issues them to one EXU.
// A slot's tag {RVS_ID, slot} stays reserved until its own result returns
// on the CDB, so a tag is never in flight twice.
// Optional feature: define RVS_AGE_ORDER_EN for oldest-first issue via an
// age matrix; otherwise the lowest-index READY slot issues.

module rvs_station #(
    parameter int TAG_W  = 4,
    parameter int OPC_W  = 4,
    parameter int DEPTH  = 4,
    parameter int RVS_ID = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    dec2rvs_itf.rvs dec,
    rvs2exu_itf.rvs exu,
    cdb_itf.slv     cdb
);

    localparam int SLOT_W = $clog2(DEPTH);
    localparam int ID_W   = TAG_W - SLOT_W;
    localparam logic [ID_W-1:0] ID = ID_W'(RVS_ID);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_WAIT   = 2'd1,
        S_READY  = 2'd2,
        S_ISSUED = 2'd3
    } slot_st_t;

    slot_st_t         r_state     [DEPTH];
    slot_st_t         w_state_nxt [DEPTH];
    logic [DEPTH-1:0] r_s1_vld, r_s2_vld;
    logic [DEPTH-1:0] w_s1_vld_nxt, w_s2_vld_nxt;
    logic [DEPTH-1:0] w_s1_cap, w_s2_cap;
    logic [TAG_W-1:0] r_s1_tag  [DEPTH];
    logic [TAG_W-1:0] r_s2_tag  [DEPTH];
    logic [31:0]      r_s1_data [DEPTH];
    logic [31:0]      r_s2_data [DEPTH];
    logic [OPC_W-1:0] r_opc     [DEPTH];
    logic [11:0]      r_off     [DEPTH];

    logic [DEPTH-1:0]  w_free, w_ready, w_rel_vec, w_alloc_vec;
    logic [SLOT_W-1:0] w_alloc_idx, w_sel_idx;
    logic              w_any_free, w_alloc, w_issue;
    logic              w_a_s1_hit, w_a_s2_hit;

    // Per-slot status decode, including release by a matching CDB write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i]    = (r_state[i] == S_FREE);
            w_ready[i]   = (r_state[i] == S_READY);
            w_rel_vec[i] = (r_state[i] == S_ISSUED) && cdb.wr &&
                           (cdb.tag == {ID, SLOT_W'(i)});
        end
    end

    // Lowest free slot for dispatch; depends on registered state only
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_free[i]) w_alloc_idx = SLOT_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_alloc_vec[i] = w_alloc && (w_alloc_idx == SLOT_W'(i));
        end
    end

    assign w_any_free = |w_free;
    assign w_alloc    = dec.req && w_any_free;
    assign dec.rdy    = w_any_free;
    assign dec.tag    = {ID, w_alloc_idx};

    // Same-cycle CDB bypass for operands that are missing at dispatch
    assign w_a_s1_hit = cdb.wr && (cdb.tag == dec.src1_tag);
    assign w_a_s2_hit = cdb.wr && (cdb.tag == dec.src2_tag);

`ifdef RVS_AGE_ORDER_EN
    // r_age[i][j] = 1 means slot j was allocated before slot i
    logic [DEPTH-1:0] r_age [DEPTH];

    // Oldest READY slot: the one with no older READY slot
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i] && ((r_age[i] & w_ready) == '0)) w_sel_idx = SLOT_W'(i);
        end
    end

    // Age matrix: new row = current occupancy; released slots drop out of every row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_vec[i])    r_age[i] <= ~w_free & ~w_rel_vec;
                else if (w_rel_vec[i]) r_age[i] <= '0;
                else                   r_age[i] <= r_age[i] & ~w_rel_vec;
            end
        end
    end
`else
    // Lowest-index READY slot wins
    always_comb begin
        w_sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) w_sel_idx = SLOT_W'(i);
        end
    end
`endif

    assign exu.req = |w_ready;
    assign w_issue = exu.req && exu.rdy;

    // Issue port contents, forced to zero when nothing is presented
    always_comb begin
        exu.tag    = '0;
        exu.opc    = '0;
        exu.src1   = '0;
        exu.src2   = '0;
        exu.offset = '0;
        if (exu.req) begin
            exu.tag    = {ID, w_sel_idx};
            exu.opc    = r_opc[w_sel_idx];
            exu.src1   = r_s1_data[w_sel_idx];
            exu.src2   = r_s2_data[w_sel_idx];
            exu.offset = r_off[w_sel_idx];
        end
    end

    // Per-slot next state: allocate, snoop, issue, release
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_s1_vld_nxt[i] = r_s1_vld[i];
            w_s2_vld_nxt[i] = r_s2_vld[i];
            w_s1_cap[i]     = 1'b0;
            w_s2_cap[i]     = 1'b0;
            case (r_state[i])
                S_FREE: begin
                    if (w_alloc_vec[i]) begin
                        w_s1_vld_nxt[i] = dec.src1_vld || w_a_s1_hit;
                        w_s2_vld_nxt[i] = dec.src2_vld || w_a_s2_hit;
                        w_state_nxt[i]  = (w_s1_vld_nxt[i] && w_s2_vld_nxt[i]) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!r_s1_vld[i] && cdb.wr && (cdb.tag == r_s1_tag[i])) begin
                        w_s1_vld_nxt[i] = 1'b1;
                        w_s1_cap[i]     = 1'b1;
                    end
                    if (!r_s2_vld[i] && cdb.wr && (cdb.tag == r_s2_tag[i])) begin
                        w_s2_vld_nxt[i] = 1'b1;
                        w_s2_cap[i]     = 1'b1;
                    end
                    if (w_s1_vld_nxt[i] && w_s2_vld_nxt[i]) w_state_nxt[i] = S_READY;
                end
                S_READY: begin
                    if (w_issue && (w_sel_idx == SLOT_W'(i))) w_state_nxt[i] = S_ISSUED;
                end
                S_ISSUED: begin
                    if (w_rel_vec[i]) begin
                        w_state_nxt[i]  = S_FREE;
                        w_s1_vld_nxt[i] = 1'b0;
                        w_s2_vld_nxt[i] = 1'b0;
                    end
                end
                default: w_state_nxt[i] = S_FREE;
            endcase
        end
    end

    // Slot control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= S_FREE;
            r_s1_vld <= '0;
            r_s2_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= w_state_nxt[i];
            r_s1_vld <= w_s1_vld_nxt;
            r_s2_vld <= w_s2_vld_nxt;
        end
    end

    // Slot payload; validity is carried by the control registers above
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc_vec[i]) begin
                r_opc[i]     <= dec.opc;
                r_off[i]     <= dec.offset;
                r_s1_tag[i]  <= dec.src1_tag;
                r_s2_tag[i]  <= dec.src2_tag;
                r_s1_data[i] <= dec.src1_vld ? dec.src1_wdata : cdb.wdata;
                r_s2_data[i] <= dec.src2_vld ? dec.src2_wdata : cdb.wdata;
            end else begin
                if (w_s1_cap[i]) r_s1_data[i] <= cdb.wdata;
                if (w_s2_cap[i]) r_s2_data[i] <= cdb.wdata;
            end
        end
    end

    // An own-station tag on the CDB must belong to an issued slot
    a_cdb_own_tag_issued: assert property (@(posedge clk) disable iff (!rst_n)
        (cdb.wr && (cdb.tag[TAG_W-1:SLOT_W] == ID)) |-> (r_state[cdb.tag[SLOT_W-1:0]] == S_ISSUED));

endmodule

// File: tb/tb_rvs_station.sv
// Bench for rvs_station (DEPTH=4, RVS_ID=1, own tags 0x4..0x7).
// Cycle vectors in a table plus hand-written issue-order and reset sequences.

module tb_rvs_station;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec2rvs_itf #(.TAG_W(4), .OPC_W(4)) u_dec();
    rvs2exu_itf #(.TAG_W(4), .OPC_W(4)) u_exu();
    cdb_itf     #(.TAG_W(4))            u_cdb();

    rvs_station #(.TAG_W(4), .OPC_W(4), .DEPTH(4), .RVS_ID(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (u_dec),
        .exu   (u_exu),
        .cdb   (u_cdb)
    );

    typedef struct {
        logic        req;
        logic [3:0]  opc;
        logic        s1v;
        logic [3:0]  s1t;
        logic [31:0] s1d;
        logic [31:0] s2d;
        logic        xrdy;
        logic        cwr;
        logic [3:0]  ctag;
        logic [31:0] cdat;
        logic        e_rdy;
        logic [3:0]  e_dtag;
        logic        e_xreq;
        logic [3:0]  e_xtag;
        logic [3:0]  e_xopc;
        logic [31:0] e_x1;
        logic [31:0] e_x2;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t V(input int req, input int opc, input int s1v, input int s1t,
                               input int s1d, input int s2d, input int xrdy, input int cwr,
                               input int ctag, input int cdat, input int e_rdy, input int e_dtag,
                               input int e_xreq, input int e_xtag, input int e_xopc,
                               input int e_x1, input int e_x2);
        vec_t v;
        v.req = 1'(req);   v.opc = 4'(opc);   v.s1v = 1'(s1v);   v.s1t = 4'(s1t);
        v.s1d = 32'(s1d);  v.s2d = 32'(s2d);  v.xrdy = 1'(xrdy); v.cwr = 1'(cwr);
        v.ctag = 4'(ctag); v.cdat = 32'(cdat);
        v.e_rdy = 1'(e_rdy);   v.e_dtag = 4'(e_dtag); v.e_xreq = 1'(e_xreq);
        v.e_xtag = 4'(e_xtag); v.e_xopc = 4'(e_xopc);
        v.e_x1 = 32'(e_x1);    v.e_x2 = 32'(e_x2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // src2 is always supplied valid; src1 may be pending on a tag
    task automatic drv(input int req, input int opc, input int s1v, input int s1t,
                       input int s1d, input int s2d, input int xrdy, input int cwr,
                       input int ctag, input int cdat);
        u_dec.req        = 1'(req);
        u_dec.opc        = 4'(opc);
        u_dec.src1_vld   = 1'(s1v);
        u_dec.src1_tag   = 4'(s1t);
        u_dec.src1_wdata = 32'(s1d);
        u_dec.src2_vld   = 1'b1;
        u_dec.src2_tag   = 4'h0;
        u_dec.src2_wdata = 32'(s2d);
        u_dec.offset     = 12'h0;
        u_exu.rdy        = 1'(xrdy);
        u_cdb.wr         = 1'(cwr);
        u_cdb.tag        = 4'(ctag);
        u_cdb.wdata      = 32'(cdat);
    endtask

    task automatic idle();
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [3:0]  ord_tag [3];
    logic [31:0] ord_x1  [3];

    initial begin
        // --- 1: ready-at-dispatch op, issue, release
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,4,0,0,0,0,0));
        tv.push_back(V(1,3,1,0,'h10,'h20,    0,0,0,0,          1,4,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          1,0,0,0,          1,5,1,4,3,'h10,'h20));
        tv.push_back(V(0,0,1,0,0,0,          0,1,4,'h1234,     1,5,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,4,0,0,0,0,0));
        // --- 2: operand pending on tag 0x9, supplied by a later CDB write
        tv.push_back(V(1,2,0,9,0,7,          0,0,0,0,          1,4,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,5,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,1,9,'hDEAD,     1,5,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          1,0,0,0,          1,5,1,4,2,'hDEAD,7));
        tv.push_back(V(0,0,1,0,0,0,          0,1,4,0,          1,5,0,0,0,0,0));
        // --- 3: alloc-cycle CDB bypass
        tv.push_back(V(1,5,0,'hA,0,'h66,     0,1,'hA,'h55,     1,4,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          1,0,0,0,          1,5,1,4,5,'h55,'h66));
        tv.push_back(V(0,0,1,0,0,0,          0,1,4,0,          1,5,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,4,0,0,0,0,0));
        // --- 4: fill all slots, held 5th request, release of slot 2
        tv.push_back(V(1,1,1,0,'h100,'h200,  0,0,0,0,          1,4,0,0,0,0,0));
        tv.push_back(V(1,1,1,0,'h101,'h201,  0,0,0,0,          1,5,1,4,1,'h100,'h200));
        tv.push_back(V(1,1,1,0,'h102,'h202,  0,0,0,0,          1,6,1,4,1,'h100,'h200));
        tv.push_back(V(1,1,1,0,'h103,'h203,  0,0,0,0,          1,7,1,4,1,'h100,'h200));
        tv.push_back(V(1,9,1,0,'h999,'h999,  0,0,0,0,          0,0,1,4,1,'h100,'h200));
        tv.push_back(V(1,9,1,0,'h999,'h999,  1,0,0,0,          0,0,1,4,1,'h100,'h200));
        tv.push_back(V(1,9,1,0,'h999,'h999,  1,0,0,0,          0,0,1,5,1,'h101,'h201));
        tv.push_back(V(1,9,1,0,'h999,'h999,  1,0,0,0,          0,0,1,6,1,'h102,'h202));
        tv.push_back(V(0,0,1,0,0,0,          0,1,6,0,          0,0,1,7,1,'h103,'h203));
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,6,1,7,1,'h103,'h203));
        tv.push_back(V(0,0,1,0,0,0,          1,1,4,0,          1,6,1,7,1,'h103,'h203));
        tv.push_back(V(0,0,1,0,0,0,          0,1,5,0,          1,4,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,1,7,0,          1,4,0,0,0,0,0));
        tv.push_back(V(0,0,1,0,0,0,          0,0,0,0,          1,4,0,0,0,0,0));

        idle();
        repeat (2) @(negedge clk);
        chk("rst_dec_rdy", 32'(u_dec.rdy), 1);
        chk("rst_dec_tag", 32'(u_dec.tag), 4);
        chk("rst_exu_req", 32'(u_exu.req), 0);
        rst_n = 1'b1;

        foreach (tv[k]) begin
            @(negedge clk);
            drv(tv[k].req, tv[k].opc, tv[k].s1v, tv[k].s1t, tv[k].s1d, tv[k].s2d,
                tv[k].xrdy, tv[k].cwr, tv[k].ctag, tv[k].cdat);
            #1;
            chk($sformatf("v%0d_dec_rdy", k), 32'(u_dec.rdy), 32'(tv[k].e_rdy));
            if (tv[k].e_rdy) chk($sformatf("v%0d_dec_tag", k), 32'(u_dec.tag), 32'(tv[k].e_dtag));
            chk($sformatf("v%0d_exu_req", k), 32'(u_exu.req), 32'(tv[k].e_xreq));
            chk($sformatf("v%0d_exu_tag", k), 32'(u_exu.tag), 32'(tv[k].e_xtag));
            chk($sformatf("v%0d_exu_opc", k), 32'(u_exu.opc), 32'(tv[k].e_xopc));
            chk($sformatf("v%0d_exu_src1", k), u_exu.src1, tv[k].e_x1);
            chk($sformatf("v%0d_exu_src2", k), u_exu.src2, tv[k].e_x2);
        end

        // --- 5: issue order A@0 ready, B@1 waits on 0x9, C@2 ready, D@0 after A retires
`ifdef RVS_AGE_ORDER_EN
        ord_tag[0] = 4'h5; ord_x1[0] = 32'hB1;
        ord_tag[1] = 4'h6; ord_x1[1] = 32'hC1;
        ord_tag[2] = 4'h4; ord_x1[2] = 32'hD1;
`else
        ord_tag[0] = 4'h4; ord_x1[0] = 32'hD1;
        ord_tag[1] = 4'h5; ord_x1[1] = 32'hB1;
        ord_tag[2] = 4'h6; ord_x1[2] = 32'hC1;
`endif
        @(negedge clk); drv(1, 1, 1, 0, 'hA1, 'hA2, 0, 0, 0, 0);
        #1 chk("t5_dtag_A", 32'(u_dec.tag), 4);
        @(negedge clk); drv(1, 2, 0, 9, 0, 'hB2, 0, 0, 0, 0);
        #1 chk("t5_dtag_B", 32'(u_dec.tag), 5);
        @(negedge clk); drv(1, 3, 1, 0, 'hC1, 'hC2, 0, 0, 0, 0);
        #1 chk("t5_dtag_C", 32'(u_dec.tag), 6);
        @(negedge clk); drv(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        #1 chk("t5_issue_A", 32'(u_exu.tag), 4);
        @(negedge clk); drv(0, 0, 1, 0, 0, 0, 0, 1, 4, 0);
        #1 chk("t5_only_C", 32'(u_exu.tag), 6);
        @(negedge clk); drv(1, 4, 1, 0, 'hD1, 'hD2, 0, 1, 9, 'hB1);
        #1 chk("t5_dtag_D", 32'(u_dec.tag), 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drv(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
            #1;
            chk($sformatf("t5_order%0d_req", k), 32'(u_exu.req), 1);
            chk($sformatf("t5_order%0d_tag", k), 32'(u_exu.tag), 32'(ord_tag[k]));
            chk($sformatf("t5_order%0d_src1", k), u_exu.src1, ord_x1[k]);
        end
        @(negedge clk); drv(0, 0, 1, 0, 0, 0, 0, 1, 4, 0);
        #1 chk("t5_all_issued", 32'(u_exu.req), 0);
        @(negedge clk); drv(0, 0, 1, 0, 0, 0, 0, 1, 5, 0);
        @(negedge clk); drv(0, 0, 1, 0, 0, 0, 0, 1, 6, 0);
        @(negedge clk); idle();
        #1 chk("t5_empty_tag", 32'(u_dec.tag), 4);

        // --- 6: asynchronous reset with three slots occupied
        @(negedge clk); drv(1, 1, 1, 0, 'h31, 'h32, 0, 0, 0, 0);
        @(negedge clk); drv(1, 1, 1, 0, 'h41, 'h42, 0, 0, 0, 0);
        @(negedge clk); drv(1, 1, 1, 0, 'h51, 'h52, 0, 0, 0, 0);
        @(negedge clk); idle();
        #1 chk("t6_pre_req", 32'(u_exu.req), 1);
        chk("t6_pre_tag", 32'(u_dec.tag), 7);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_exu_req", 32'(u_exu.req), 0);
        chk("t6_rst_dec_rdy", 32'(u_dec.rdy), 1);
        chk("t6_rst_dec_tag", 32'(u_dec.tag), 4);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drv(1, 7, 1, 0, 'h77, 'h88, 0, 0, 0, 0);
        #1 chk("t6_post_dtag", 32'(u_dec.tag), 4);
        @(negedge clk); idle();
        #1;
        chk("t6_post_req", 32'(u_exu.req), 1);
        chk("t6_post_xtag", 32'(u_exu.tag), 4);
        chk("t6_post_src1", u_exu.src1, 32'h77);
        chk("t6_post_dtag2", 32'(u_dec.tag), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
